// File: rtl/debug_unit_pkg.sv
// rtl/debug_unit_pkg.sv - shared constants and state types for the debug unit
package debug_unit_pkg;

    localparam int CLKS_PER_BIT_DEF = 5208;

    localparam logic [7:0] CMD_CONT      = 8'h04;
    localparam logic [7:0] CMD_STEP_MODE = 8'h05;
    localparam logic [7:0] CMD_STEP      = 8'h06;
    localparam logic [7:0] CMD_EXIT      = 8'h07;
    localparam logic [7:0] CMD_RST_PC    = 8'h08;
    localparam logic [7:0] RSP_ERR       = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_REPLY
    } dbg_state_e;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - 8N1 UART transmitter and mid-bit sampling receiver
module uart_transceiver
    import debug_unit_pkg::*;
#(
    parameter int BYTE         = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tx_start_i,
    input  logic [BYTE-1:0] tx_data_i,
    output logic            tx_line_o,
    output logic            tx_busy_o,
    input  logic            rx_line_i,
    output logic [BYTE-1:0] rx_data_o,
    output logic            rx_valid_o
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(BYTE);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTE - 1);

    uart_state_e     tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [IW-1:0]   tx_idx_q;
    logic [BYTE-1:0] tx_shift_q;
    logic            tx_line_q;

    uart_state_e     rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [IW-1:0]   rx_idx_q;
    logic [BYTE-1:0] rx_shift_q;
    logic [BYTE-1:0] rx_data_q;
    logic            rx_valid_q;

    // Transmitter: latch the byte when idle, then start, data LSB first, stop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= U_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                U_IDLE: begin
                    tx_line_q <= 1'b1;
                    if (tx_start_i) begin
                        tx_shift_q <= tx_data_i;
                        tx_line_q  <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= U_START;
                    end
                end
                U_START: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_line_q  <= tx_shift_q[0];
                        tx_state_q <= U_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == IDX_LAST) begin
                            tx_line_q  <= 1'b1;
                            tx_state_q <= U_STOP;
                        end else begin
                            tx_idx_q   <= tx_idx_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_line_q  <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                U_STOP: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= U_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= U_IDLE;
            endcase
        end
    end

    // Receiver: confirm start at mid-bit, sample each bit centre, drop bad stop bits
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_state_q <= U_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                U_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_line_i) rx_state_q <= U_START;
                end
                U_START: begin
                    if (rx_cnt_q == CNT_HALF) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rx_line_i ? U_IDLE : U_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                U_DATA: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_line_i, rx_shift_q[BYTE-1:1]};
                        if (rx_idx_q == IDX_LAST) rx_state_q <= U_STOP;
                        else                      rx_idx_q   <= rx_idx_q + 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                U_STOP: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= U_IDLE;
                        if (rx_line_i) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= U_IDLE;
            endcase
        end
    end

    assign tx_line_o  = tx_line_q;
    assign tx_busy_o  = (tx_state_q != U_IDLE);
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule

// File: rtl/debug_unit_top.sv
// rtl/debug_unit_top.sv - host UART, debug UART and command FSM driving a PC stub
module debug_unit_top
    import debug_unit_pkg::*;
#(
    parameter int BYTE         = 8,
    parameter int ADDR         = 5,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [BYTE-1:0] command,
    input  logic            send,
    output logic [BYTE-1:0] o_response,
    output logic            o_response_valid,
    output logic [ADDR-1:0] o_pc,
    output logic            o_step_mode,
    output logic            o_halt,
    output logic            o_busy
);

    localparam logic [ADDR-1:0] PC_MAX = '1;

    logic            host_line;
    logic            dbg_line;
    logic [BYTE-1:0] dbg_rx_data;
    logic            dbg_rx_valid;
    logic            dbg_tx_busy;

    dbg_state_e      state_q;
    logic [ADDR-1:0] pc_q;
    logic            step_mode_q;
    logic            halt_q;
    logic [BYTE-1:0] reply_q;
    logic            reply_start_q;
    logic            reply_wait_q;

    logic [ADDR-1:0] pc_inc_d;
    logic [BYTE-1:0] pc_byte;
    logic [BYTE-1:0] pc_inc_byte;

    assign pc_inc_d    = pc_q + 1'b1;
    assign pc_byte     = {{(BYTE-ADDR){1'b0}}, pc_q};
    assign pc_inc_byte = {{(BYTE-ADDR){1'b0}}, pc_inc_d};

    uart_transceiver #(.BYTE(BYTE), .CLKS_PER_BIT(CLKS_PER_BIT)) u_host (
        .clk_i      (i_clock),
        .rst_i      (i_reset),
        .tx_start_i (send),
        .tx_data_i  (command),
        .tx_line_o  (host_line),
        .tx_busy_o  (o_busy),
        .rx_line_i  (dbg_line),
        .rx_data_o  (o_response),
        .rx_valid_o (o_response_valid)
    );

    uart_transceiver #(.BYTE(BYTE), .CLKS_PER_BIT(CLKS_PER_BIT)) u_dbg (
        .clk_i      (i_clock),
        .rst_i      (i_reset),
        .tx_start_i (reply_start_q),
        .tx_data_i  (reply_q),
        .tx_line_o  (dbg_line),
        .tx_busy_o  (dbg_tx_busy),
        .rx_line_i  (host_line),
        .rx_data_o  (dbg_rx_data),
        .rx_valid_o (dbg_rx_valid)
    );

    // Command FSM: decode received bytes, run/step the PC stub, send one reply per command
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            step_mode_q   <= 1'b0;
            halt_q        <= 1'b0;
            reply_q       <= '0;
            reply_start_q <= 1'b0;
            reply_wait_q  <= 1'b0;
        end else begin
            reply_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_STEP: begin
                    if (dbg_rx_valid) begin
                        state_q       <= ST_REPLY;
                        reply_start_q <= 1'b1;
                        reply_wait_q  <= 1'b0;
                        reply_q       <= RSP_ERR;
                        case (dbg_rx_data)
                            CMD_CONT: begin
                                state_q       <= ST_RUN;
                                reply_start_q <= 1'b0;
                            end
                            CMD_STEP_MODE: begin
                                if (state_q == ST_IDLE) begin
                                    step_mode_q <= 1'b1;
                                    reply_q     <= pc_byte;
                                end
                            end
                            CMD_STEP: begin
                                if (state_q == ST_STEP) begin
                                    if (halt_q) begin
                                        reply_q <= pc_byte;
                                    end else begin
                                        pc_q    <= pc_inc_d;
                                        halt_q  <= (pc_inc_d == PC_MAX);
                                        reply_q <= pc_inc_byte;
                                    end
                                end
                            end
                            CMD_EXIT: begin
                                if (state_q == ST_STEP) begin
                                    step_mode_q <= 1'b0;
                                    reply_q     <= pc_byte;
                                end
                            end
                            CMD_RST_PC: begin
                                pc_q    <= '0;
                                halt_q  <= 1'b0;
                                reply_q <= '0;
                            end
                            default: reply_q <= RSP_ERR;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (pc_q == PC_MAX) begin
                        halt_q        <= 1'b1;
                        reply_q       <= pc_byte;
                        reply_start_q <= 1'b1;
                        reply_wait_q  <= 1'b0;
                        state_q       <= ST_REPLY;
                    end else begin
                        pc_q <= pc_inc_d;
                    end
                end
                ST_REPLY: begin
                    // The TX only reports busy the cycle after it sees the start pulse
                    if (dbg_tx_busy) begin
                        reply_wait_q <= 1'b1;
                    end else if (reply_wait_q) begin
                        reply_wait_q <= 1'b0;
                        state_q      <= step_mode_q ? ST_STEP : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_pc        = pc_q;
    assign o_step_mode = step_mode_q;
    assign o_halt      = halt_q;

endmodule

// File: tb/tb_debug_unit_top.sv
// tb/tb_debug_unit_top.sv - scoreboard bench for debug_unit_top
module tb_debug_unit_top;

    localparam int CPB   = 16;
    localparam int BOUND = 30 * CPB + 100;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] command = 8'h00;
    logic       send    = 1'b0;
    logic [7:0] o_response;
    logic       o_response_valid;
    logic [4:0] o_pc;
    logic       o_step_mode;
    logic       o_halt;
    logic       o_busy;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 i_clock = ~i_clock;

    debug_unit_top #(.BYTE(8), .ADDR(5), .CLKS_PER_BIT(CPB)) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .command          (command),
        .send             (send),
        .o_response       (o_response),
        .o_response_valid (o_response_valid),
        .o_pc             (o_pc),
        .o_step_mode      (o_step_mode),
        .o_halt           (o_halt),
        .o_busy           (o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected byte
    always @(negedge i_clock) begin
        if (o_response_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_response actual=%0h required=none", o_response);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("response", {24'h0, o_response}, {24'h0, mon_exp});
            end
        end
    end

    task automatic pulse_send(input logic [7:0] c);
        @(negedge i_clock);
        command = c;
        send    = 1'b1;
        @(negedge i_clock);
        send    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < BOUND) begin
            @(negedge i_clock);
            n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (2 * CPB) @(negedge i_clock);
    endtask

    task automatic cmd(input logic [7:0] c, input logic [7:0] e, input string name);
        exp_q.push_back(e);
        pulse_send(c);
        drain(name);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #50;
        chk("rst_response", o_response, 0);
        chk("rst_valid", o_response_valid, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_step", o_step_mode, 0);
        chk("rst_halt", o_halt, 0);
        chk("rst_busy", o_busy, 0);
        #50 i_reset = 1'b0;
        repeat (3) @(negedge i_clock);

        // Continuous run with busy-length measurement
        exp_q.push_back(8'h1F);
        pulse_send(8'h04);
        n = 0;
        while (o_busy === 1'b1 && n < BOUND) begin
            n++;
            @(negedge i_clock);
        end
        chk("busy_len", n, 10 * CPB);
        drain("cont_reply");
        chk("cont_pc", o_pc, 31);
        chk("cont_halt", o_halt, 1);
        chk("cont_step", o_step_mode, 0);

        cmd(8'h08, 8'h00, "rstpc_reply");
        chk("rstpc_pc", o_pc, 0);
        chk("rstpc_halt", o_halt, 0);
        cmd(8'h04, 8'h1F, "cont2_reply");
        chk("cont2_halt", o_halt, 1);
        cmd(8'h08, 8'h00, "rstpc2_reply");

        // Step mode sequence
        cmd(8'h05, 8'h00, "stepmode_reply");
        chk("stepmode_on", o_step_mode, 1);
        cmd(8'h06, 8'h01, "step1_reply");
        chk("step1_pc", o_pc, 1);
        cmd(8'h06, 8'h02, "step2_reply");
        cmd(8'h07, 8'h02, "exit_reply");
        chk("exit_step", o_step_mode, 0);
        chk("exit_pc", o_pc, 2);

        // Wrong-state and unknown commands
        cmd(8'h06, 8'hEE, "step_idle_reply");
        chk("step_idle_pc", o_pc, 2);
        cmd(8'h99, 8'hEE, "bad_reply");
        chk("bad_pc", o_pc, 2);
        chk("bad_step", o_step_mode, 0);

        // Send while busy is ignored
        exp_q.push_back(8'h02);
        pulse_send(8'h05);
        repeat (20) @(negedge i_clock);
        chk("busy_mid", o_busy, 1);
        command = 8'h99;
        send    = 1'b1;
        @(negedge i_clock);
        send    = 1'b0;
        drain("busy_reply");
        repeat (30 * CPB) @(negedge i_clock);
        chk("busy_step", o_step_mode, 1);
        cmd(8'h07, 8'h02, "exit2_reply");

        // Reset in the middle of a host frame
        pulse_send(8'h05);
        repeat (5 * CPB) @(negedge i_clock);
        #2 i_reset = 1'b1;
        #1;
        chk("mf_busy", o_busy, 0);
        chk("mf_pc", o_pc, 0);
        chk("mf_response", o_response, 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (30 * CPB) @(negedge i_clock);
        chk("mf_after_step", o_step_mode, 0);

        // Reset in the middle of a run
        pulse_send(8'h04);
        n = 0;
        while (o_pc == 5'd0 && n < BOUND) begin
            @(negedge i_clock);
            n++;
        end
        chk("run_started", (o_pc != 5'd0), 1);
        #2 i_reset = 1'b1;
        #1;
        chk("mr_pc", o_pc, 0);
        chk("mr_halt", o_halt, 0);
        @(negedge i_clock);
        i_reset = 1'b0;
        repeat (30 * CPB) @(negedge i_clock);
        chk("mr_after_pc", o_pc, 0);

        cmd(8'h04, 8'h1F, "post_reset_reply");
        chk("post_reset_halt", o_halt, 1);
        chk("post_reset_pc", o_pc, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
